// File: rtl/arm_cache_pkg.sv
// Shared types and constants for the two-way write-through data cache.
//   cache_state_t : controller FSM states
//   LINE_W        : line width in bits (two 32-bit words)
//   WORD_SEL_BIT  : address bit selecting the word within a line
//   INDEX_LSB     : lowest address bit of the set index
//   TAG_LSB       : lowest address bit of the tag
//   word_of()     : pick one word out of a line
package arm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } cache_state_t;

  localparam int LINE_W       = 64;
  localparam int WORD_W       = 32;
  localparam int WORD_SEL_BIT = 2;
  localparam int INDEX_LSB    = 3;
  localparam int TAG_LSB      = 9;

  function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic              sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid bit, tag and 64-bit line.
//   clk, rst     : clock, async active-low reset (clears valid bits only)
//   idx          : set index, shared by read and write ports
//   vld/tag_q/line_q : combinational read of set idx
//   fill_en      : write whole line + tag, mark valid
//   word_en      : overwrite one word (word_sel) of an existing line
module cache_way_array
  import arm_cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              vld,
  output logic [TAG_W-1:0]  tag_q,
  output logic [LINE_W-1:0] line_q,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              word_en,
  input  logic              word_sel,
  input  logic [WORD_W-1:0] word_data
);

  logic [SETS-1:0]   vld_mem;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] line_mem [SETS];

  assign vld    = vld_mem[idx];
  assign tag_q  = tag_mem[idx];
  assign line_q = line_mem[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         vld_mem      <= '0;
    else if (fill_en) vld_mem[idx] <= 1'b1;
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      line_mem[idx] <= fill_line;
    end else if (word_en) begin
      if (word_sel) line_mem[idx][LINE_W-1:WORD_W] <= word_data;
      else          line_mem[idx][WORD_W-1:0]      <= word_data;
    end
  end

endmodule

// File: rtl/sram_cache_ctrl.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete combinationally in the request cycle; read misses fill
// a line from the SRAM controller; every store is forwarded to SRAM and
// updates the cache only on a hit. ready low = pipeline memory freeze.
//   clk, rst                 : clock, async active-low reset
//   rd_en, wr_en, addr, wdata: CPU request (held until ready)
//   rdata, ready             : CPU response
//   sram_*                   : line-read / word-write port to SRAM controller
module sram_cache_ctrl
  import arm_cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAYS  = 2;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;

  assign idx      = addr[INDEX_LSB +: IDX_W];
  assign tag      = addr[TAG_LSB +: TAG_W];
  assign word_sel = addr[WORD_SEL_BIT];

  cache_state_t               state;
  logic [SETS-1:0]            lru;
  logic [WAYS-1:0]            way_vld, way_hit, fill_en, word_en;
  logic [WAYS-1:0][TAG_W-1:0] way_tag;
  logic [WAYS-1:0][LINE_W-1:0] way_line;
  logic hit, hit_way, victim, rd_hit, fill_done, wr_done;

  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  // Fill invalid ways first (way 0 preferred) before evicting by LRU.
  assign victim    = !way_vld[0] ? 1'b0 : (!way_vld[1] ? 1'b1 : lru[idx]);
  assign rd_hit    = (state == IDLE) && rd_en && !wr_en && hit;
  assign fill_done = (state == RD_MISS) && sram_ready;
  assign wr_done   = (state == WR) && sram_ready;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = way_vld[w] && (way_tag[w] == tag);
    assign fill_en[w] = fill_done && (victim == 1'(w));
    assign word_en[w] = wr_done && way_hit[w];

    cache_way_array #(.SETS(SETS), .TAG_W(TAG_W)) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .vld       (way_vld[w]),
      .tag_q     (way_tag[w]),
      .line_q    (way_line[w]),
      .fill_en   (fill_en[w]),
      .fill_tag  (tag),
      .fill_line (sram_rdata),
      .word_en   (word_en[w]),
      .word_sel  (word_sel),
      .word_data (wdata)
    );
  end

  // IDLE is ready unless a store is pending or a load misses; sram_ready
  // is only honoured in the busy states, so a stale pulse is ignored.
  assign ready = (state == IDLE) ? (!wr_en && (!rd_en || hit))
                                 : sram_ready;

  always_comb begin
    rdata = '0;
    if (rd_hit)         rdata = word_of(way_line[hit_way], word_sel);
    else if (fill_done) rdata = word_of(sram_rdata, word_sel);
  end

  assign sram_addr  = (state == WR) ? addr : {addr[31:3], 3'b000};
  assign sram_wdata = wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lru        <= '0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            state      <= WR;
            sram_wr_en <= 1'b1;
          end else if (rd_en) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
            end else begin
              state      <= RD_MISS;
              sram_rd_en <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            lru[idx]   <= ~victim;
            state      <= IDLE;
            sram_rd_en <= 1'b0;
          end
        end
        WR: begin
          if (sram_ready) begin
            if (hit) lru[idx] <= ~hit_way;
            state      <= IDLE;
            sram_wr_en <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sram_rd_en <= 1'b0;
          sram_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_cache_ctrl.md
# sram_cache_ctrl

Two-way set-associative, write-through, no-write-allocate data cache between the Memory stage and the SRAM controller. Read hits finish in the request cycle. Misses and all writes go to the SRAM controller. While the cache is busy it holds `ready` low, and the pipeline uses that signal as its memory freeze.

## Interface
Parameters:
- `SETS`, 64: number of sets; index width is log2(SETS).
- `TAG_W`, 10: tag width; address bits [18:9] at default.

Ports:
- `clk`  in  1  clock; rising edge active.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  CPU load request; held until `ready`.
- `wr_en`  in  1  CPU store request; held until `ready`.
- `addr`  in  32  byte address.
  - [2] selects the word within the line.
  - [8:3] is the index.
  - [18:9] is the tag.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid when `ready & rd_en`.
- `ready`  out  1  request complete. Also 1 in IDLE when there is no request.
- `sram_rd_en`  out  1  line-read request to the SRAM controller.
- `sram_wr_en`  out  1  word-write request to the SRAM controller.
- `sram_addr`  out  32  address to the SRAM controller.
  - Reads: line-aligned, `{addr[31:3],3'b0}`.
  - Writes: `addr`.
- `sram_wdata`  out  32  store data to the SRAM controller.
- `sram_rdata`  in  64  line data. Word 0 is [31:0], at `addr[2]`=0.
- `sram_ready`  in  1  SRAM access complete; a single-cycle pulse.

## Operation
- Per set storage, for each way: valid bit, TAG_W tag, 64-bit line. One LRU bit per set.
  - `lru`=w means way w is the victim.
- States: IDLE, RD_MISS, WR.
- In IDLE with `wr_en`: go to WR. `wr_en` wins if both enables are high.
- In IDLE with `rd_en`, hit in way w:
  - `ready`=1 and `rdata`=selected word, both combinational.
  - `lru[set]`←~w at the clock edge.
  - Stay in IDLE.
- In IDLE with `rd_en`, miss: go to RD_MISS.
- RD_MISS:
  - Hold `sram_rd_en`=1 and the aligned address.
  - On `sram_ready`, fill the victim way: valid←1, tag←addr tag, line←`sram_rdata`.
  - Victim choice: first invalid way, way 0 preferred; otherwise `lru[set]`.
  - Set `lru[set]`←~victim.
  - `ready`=1 and `rdata`=word of `sram_rdata` chosen by `addr[2]`, combinational, same cycle.
  - Go to IDLE.
- WR:
  - Hold `sram_wr_en`=1 with `sram_addr`=`addr` and `sram_wdata`=`wdata`.
  - On `sram_ready`, if the tag hits way w: overwrite word `addr[2]` of way w and set `lru`←~w.
  - On a write miss the cache is unchanged.
  - `ready`=1 that cycle; go to IDLE.
- `sram_rd_en` and `sram_wr_en` are never both 1.
- Both enables are deasserted in IDLE.
- Reset, including reset in the middle of an access:
  - State←IDLE; all valid and LRU bits←0; SRAM enables←0.
  - `rdata`=0 until the first hit.
  - An abandoned SRAM access is dropped; a stale `sram_ready` seen in IDLE is ignored.

## Timing
- Read hit: 0 wait cycles; `ready` goes high in the cycle the request appears.
- Read miss: one cycle to enter RD_MISS, then `ready` high in the cycle `sram_ready` pulses. Total = 1 + SRAM latency.
- Write: same as a read miss, for hits and misses alike.
- Tag compare is combinational from `addr`. Arrays update on the rising `clk` edge.
- The CPU must keep `addr`, `wdata` and its enables stable until the `ready` cycle. The new request appears the following cycle.
- A read of a line being written in the previous cycle sees the updated word, because the write updates the array at the WR completion edge.

## Structure
- Package `arm_cache_pkg` holds:
  - the state enum `cache_state_t` {IDLE, RD_MISS, WR};
  - constants `LINE_W`=64, `WORD_SEL_BIT`=2, `INDEX_LSB`=3, `TAG_LSB`=9.
- Sub-module `cache_way_array`, instantiated twice, one per way:
  - valid, tag and line storage with async clear of valid;
  - read port indexed combinationally;
  - write port with full-line fill or single-word update.
- The top level holds the LRU bit vector, the FSM, hit/victim logic and SRAM muxing.

## Test plan
- Cold read `addr`=0x400, SRAM returns line 0x22222222_11111111 after 5 cycles → `ready`=0 for 6 cycles, then `rdata`=0x11111111. A repeat read of 0x404 hits with `rdata`=0x22222222 in the same cycle, with no `sram_rd_en`.
- Fill set 0 via 0x400 and 0x600, read 0x400, then miss on 0x800 → way holding 0x600 is evicted; reads of 0x400 hit and 0x600 misses.
- Write hit 0x404←0xDEADBEEF → `sram_wr_en` with that data until `sram_ready`; next read of 0x404 hits with 0xDEADBEEF.
- Write miss 0xA00 → SRAM write issued, no fill; following read of 0xA00 misses.
- `rd_en` and `wr_en` both high → WR path taken, no `sram_rd_en`.
- `rst` low for 1 cycle during RD_MISS → SRAM enables 0 immediately; a late `sram_ready` is ignored; the previously cached 0x400 now misses.
